bcd_converter_seq: RTL

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It converts an `IN_WIDTH`-bit unsigned value into `DIGITS` packed BCD digits under a start/busy/done handshake, and flags values that do not fit in `DIGITS` digits. It sits between the counter/timer logic and the seven-segment decode path, and serves multi-digit displays of any width.

---
 rtl/bcd_converter_seq_if.sv | 14 +
 rtl/bcd_converter_seq.sv | 76 +++++++
 2 files changed

// File: rtl/bcd_converter_seq_if.sv
// bcd_converter_seq_if: start/busy/done handshake and result bus of the binary-to-BCD converter
interface bcd_converter_seq_if #(
   parameter int IN_WIDTH = 6,
   parameter int DIGITS   = 2
);
   logic                  start;
   logic [IN_WIDTH-1:0]   val_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  overflow;
   modport master (output start, val_in, input busy, done, bcd_out, overflow);
   modport slave  (input start, val_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq: double-dabble binary-to-BCD, one input bit per clock
module bcd_converter_seq #(
   parameter int IN_WIDTH = 6,
   parameter int DIGITS   = 2
) (
   input logic               clk,
   input logic               reset,
   bcd_converter_seq_if.slave bus
);
   localparam int CW = $clog2(IN_WIDTH + 1);
   localparam int SW = 4 * DIGITS;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);
   localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [IN_WIDTH-1:0] bin;
   logic [SW-1:0]       scr;
   logic [SW-1:0]       adj;
   logic [SW-1:0]       nxt_scr;
   logic                ovf_next;

   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      assign adj[4*d+:4] = scr[4*d+:4] >= 4'd5 ? scr[4*d+:4] + 4'd3 : scr[4*d+:4];
   end

   // the bit leaving the top digit is dropped, giving the value mod 10^DIGITS
   assign nxt_scr = SW'({adj, bin[IN_WIDTH-1]});

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         bin          <= '0;
         scr          <= '0;
         ovf_next     <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.bcd_out  <= '0;
         bus.overflow <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               state    <= SHIFT;
               bus.busy <= 1'b1;
               bin      <= bus.val_in;
               scr      <= '0;
               cnt      <= '0;
               ovf_next <= 64'(bus.val_in) >= LIMIT;
            end
         end else begin
            scr <= nxt_scr;
            bin <= bin << 1;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
               state        <= IDLE;
               bus.busy     <= 1'b0;
               bus.done     <= 1'b1;
               bus.bcd_out  <= nxt_scr;
               bus.overflow <= ovf_next;
            end
         end
      end
   end
endmodule
